// File: rtl/hex_adder_scan_display.sv
// Registered WIDTH-bit adder whose WIDTH+1-bit result is shown in hex on a
// time-multiplexed bank of active-low seven-segment digits.
module hex_adder_scan_display #(
    parameter int WIDTH       = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a_in,
    input  logic [WIDTH-1:0]      b_in,
    input  logic                  cin,
    input  logic                  load_btn,
    input  logic                  clear_btn,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digs,
    output logic                  cout,
    output logic                  sum_valid
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int XW = 4 * NUM_DIGITS;

    if (XW < WIDTH + 1) begin : g_bad_digits
        $error("NUM_DIGITS too small to show a %0d-bit result", WIDTH + 1);
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end

    logic [2:0]       load_sync;
    logic [2:0]       clear_sync;
    logic             load_pulse;
    logic             clear_pulse;
    logic [WIDTH:0]   result;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [XW-1:0]    ext;
    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       seg_next;

    function automatic logic [6:0] hex_map(input logic [3:0] n);
        case (n)
            4'h0: hex_map = 7'h7E;  4'h1: hex_map = 7'h30;
            4'h2: hex_map = 7'h6D;  4'h3: hex_map = 7'h79;
            4'h4: hex_map = 7'h33;  4'h5: hex_map = 7'h5B;
            4'h6: hex_map = 7'h5F;  4'h7: hex_map = 7'h70;
            4'h8: hex_map = 7'h7F;  4'h9: hex_map = 7'h7B;
            4'hA: hex_map = 7'h77;  4'hB: hex_map = 7'h1F;
            4'hC: hex_map = 7'h4E;  4'hD: hex_map = 7'h3D;
            4'hE: hex_map = 7'h4F;  default: hex_map = 7'h47;
        endcase
    endfunction

    // Synchronizer stages reset to 1 so a button held through reset looks
    // already-pressed and gives no pulse until released and pressed again.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_sync  <= '1;
            clear_sync <= '1;
        end else begin
            load_sync  <= {load_sync[1:0], load_btn};
            clear_sync <= {clear_sync[1:0], clear_btn};
        end
    end

    assign load_pulse  = load_sync[1] & ~load_sync[2];
    assign clear_pulse = clear_sync[1] & ~clear_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            sum_valid <= 1'b0;
        end else if (clear_pulse) begin
            result    <= '0;
            sum_valid <= 1'b0;
        end else if (load_pulse) begin
            result    <= {1'b0, a_in} + {1'b0, b_in} + (WIDTH+1)'(cin);
            sum_valid <= 1'b1;
        end
    end

    assign cout = result[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ext         = '0;
        ext[WIDTH:0] = result;
        nib         = ext[4*int'(idx) +: 4];
        blank       = 1'b0;
        if (BLANK_LZ != 0 && idx != '0) begin
            blank = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i >= int'(idx) && ext[4*i +: 4] != 4'h0) blank = 1'b0;
            end
        end
        seg_next = blank ? 7'h7F : ~hex_map(nib);
    end

    // Display outputs trail idx/result by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg  <= 7'b0000001;
            dp   <= 1'b0;
            digs <= NUM_DIGITS'(1);
        end else begin
            seg  <= seg_next;
            dp   <= ~(idx == '0 && !sum_valid);
            digs <= NUM_DIGITS'(1) << idx;
        end
    end

endmodule

// File: tb/tb_hex_adder_scan_display.sv
// Directed bench for hex_adder_scan_display: one instance with leading-zero
// blanking, one without, sharing clock, reset and inputs.
module tb_hex_adder_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in, b_in;
    logic       cin, load_btn, clear_btn;
    logic [6:0] seg, seg0;
    logic       dp, dp0, cout, cout0, sum_valid, sum_valid0;
    logic [3:0] digs, digs0;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'h01, S1 = 7'h4F, S3 = 7'h06,
                           S5 = 7'h24, SC = 7'h31, SB = 7'h7F;

    hex_adder_scan_display #(.WIDTH(8), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .cin(cin),
        .load_btn(load_btn), .clear_btn(clear_btn), .seg(seg), .dp(dp),
        .digs(digs), .cout(cout), .sum_valid(sum_valid));

    hex_adder_scan_display #(.WIDTH(8), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .cin(cin),
        .load_btn(load_btn), .clear_btn(clear_btn), .seg(seg0), .dp(dp0),
        .digs(digs0), .cout(cout0), .sum_valid(sum_valid0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_digit(input bit alt, input int i, output logic [6:0] s, output logic d);
        logic found;
        found = 1'b0;
        s = 'x;
        d = 1'bx;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if ((alt ? digs0 : digs) == 4'(1 << i)) begin
                found = 1'b1;
                s = alt ? seg0 : seg;
                d = alt ? dp0 : dp;
            end
        end
        check($sformatf("scan_found_d%0d", i), 32'(found), 32'd1);
    endtask

    // exp packs the expected segments as {d3, d2, d1, d0}.
    task automatic check_digits(input string tag, input bit alt, input logic [27:0] exp,
                                input logic exp_dp0);
        logic [6:0] s;
        logic       d;
        for (int i = 0; i < 4; i++) begin
            read_digit(alt, i, s, d);
            check($sformatf("%s_seg%0d", tag, i), 32'(s), 32'(exp[7*i +: 7]));
            if (i == 0) check($sformatf("%s_dp0", tag), 32'(d), 32'(exp_dp0));
        end
    endtask

    task automatic press(input int hold);
        load_btn = 1'b1;
        cycles(hold);
        load_btn = 1'b0;
        cycles(4);
    endtask

    initial begin
        rst = 1'b1; a_in = 8'hFF; b_in = 8'h01; cin = 1'b1;
        load_btn = 1'b1; clear_btn = 1'b0;

        // 1. Reset values, scan order, held button through reset gives no load.
        cycles(3);
        check("rst_digs", 32'(digs), 32'h1);
        check("rst_seg", 32'(seg), 32'(S0));
        check("rst_dp", 32'(dp), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_valid", 32'(sum_valid), 32'd0);
        rst = 1'b0;
        cycles(4);
        check("scan_hold0", 32'(digs), 32'h1);
        cycles(1);
        check("scan_1", 32'(digs), 32'h2);
        cycles(4);
        check("scan_2", 32'(digs), 32'h4);
        cycles(4);
        check("scan_3", 32'(digs), 32'h8);
        cycles(4);
        check("scan_wrap", 32'(digs), 32'h1);
        check("held_thru_rst", 32'(sum_valid), 32'd0);
        load_btn = 1'b0;
        cycles(4);
        check("release_no_load", 32'(sum_valid), 32'd0);

        // 2. FF+01+1 = 101, result appears on the third edge.
        load_btn = 1'b1;
        cycles(2);
        check("lat_2edges_cout", 32'(cout), 32'd0);
        check("lat_2edges_valid", 32'(sum_valid), 32'd0);
        cycles(1);
        check("lat_3edges_cout", 32'(cout), 32'd1);
        check("lat_3edges_valid", 32'(sum_valid), 32'd1);
        load_btn = 1'b0;
        check_digits("t2", 1'b0, {SB, S1, S0, S1}, 1'b1);

        // 3. Held button loads once; later operand change is ignored.
        a_in = 8'h3C; b_in = 8'h00; cin = 1'b0;
        load_btn = 1'b1;
        cycles(4);
        a_in = 8'h77;
        cycles(16);
        load_btn = 1'b0;
        cycles(4);
        check("t3_cout", 32'(cout), 32'd0);
        check_digits("t3", 1'b0, {SB, SB, S3, SC}, 1'b1);

        // 4. Simultaneous load and clear: clear wins.
        a_in = 8'h3C;
        load_btn = 1'b1; clear_btn = 1'b1;
        cycles(5);
        load_btn = 1'b0; clear_btn = 1'b0;
        cycles(2);
        check("t4_valid", 32'(sum_valid), 32'd0);
        check("t4_cout", 32'(cout), 32'd0);
        check_digits("t4", 1'b0, {SB, SB, SB, S0}, 1'b0);

        // 5. Result 005 with and without blanking, then reset mid-digit-2.
        a_in = 8'h05; b_in = 8'h00; cin = 1'b0;
        press(3);
        check_digits("t5_nolz", 1'b1, {S0, S0, S0, S5}, 1'b1);
        check_digits("t5_lz", 1'b0, {SB, SB, SB, S5}, 1'b1);
        begin
            logic found;
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if (digs == 4'h4) found = 1'b1;
            end
            check("t5_reach_d2", 32'(found), 32'd1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_digs", 32'(digs), 32'h1);
        check("t5_rst_seg", 32'(seg), 32'(S0));
        check("t5_rst_dp", 32'(dp), 32'd0);
        check("t5_rst_valid", 32'(sum_valid), 32'd0);
        check("t5_rst_digs0", 32'(digs0), 32'h1);
        check("t5_rst_seg0", 32'(seg0), 32'(S0));
        check("t5_rst_cout0", 32'(cout0), 32'd0);
        cycles(2);
        rst = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
